// File: rtl/matrix_c_drain.sv
// Matrix C drain: reads result rows from BRAM C and streams them out
// over a valid/ready handshake with a small elastic buffer.
module matrix_c_drain #(
   parameter int DWIDTH            = 8,
   parameter int MAT_MUL_SIZE      = 4,
   parameter int AWIDTH            = 10,
   parameter int ADDR_STRIDE_WIDTH = 8
) (
   input  logic                             clk,
   input  logic                             resetn,
   input  logic                             start,
   input  logic [AWIDTH-1:0]                base_addr,
   input  logic [ADDR_STRIDE_WIDTH-1:0]     addr_stride,
   input  logic [7:0]                       num_rows,
   output logic [AWIDTH-1:0]                bram_addr_c_ext,
   input  logic [MAT_MUL_SIZE*DWIDTH-1:0]   bram_rdata_c_ext,
   output logic [MAT_MUL_SIZE*DWIDTH-1:0]   bram_wdata_c_ext,
   output logic [MAT_MUL_SIZE-1:0]          bram_we_c_ext,
   output logic [MAT_MUL_SIZE*DWIDTH-1:0]   out_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic                             out_last,
   output logic                             busy,
   output logic                             done
);

   localparam int RW = MAT_MUL_SIZE * DWIDTH;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                      state_q;
   logic [AWIDTH-1:0]           addr_q;
   logic [ADDR_STRIDE_WIDTH-1:0] stride_q;
   logic [7:0]                  rows_q;
   logic [7:0]                  issued_q;
   // rd0: address on the bus this cycle; rd1: its data on rdata this cycle
   logic                        rd0_q, rd0_last_q;
   logic                        rd1_q, rd1_last_q;
   logic [RW-1:0]               fd_q [2];
   logic [1:0]                  fl_q;
   logic                        wptr_q, rptr_q;
   logic [1:0]                  fcnt_q, fcnt_d;
   logic [RW-1:0]               out_data_q;
   logic                        out_valid_q, out_last_q, done_q;

   logic       pop, out_free, fifo_ne, move, fifo_pop, push;
   logic [2:0] commit;
   logic       can_issue, last_issue;

   assign pop      = out_valid_q & out_ready;
   assign out_free = ~out_valid_q | out_ready;
   assign fifo_ne  = (fcnt_q != 2'd0);
   assign move     = out_free & (fifo_ne | rd1_q);
   assign fifo_pop = move & fifo_ne;
   assign push     = rd1_q & ~(move & ~fifo_ne);
   assign fcnt_d   = fcnt_q + {1'b0, push} - {1'b0, fifo_pop};

   // Rows committed behind the output register must never exceed two.
   assign commit    = {1'b0, fcnt_q} + {2'b0, rd0_q} + {2'b0, rd1_q};
   assign can_issue = commit < (move ? 3'd3 : 3'd2);
   assign last_issue = (issued_q == rows_q - 8'd1);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         stride_q    <= '0;
         rows_q      <= '0;
         issued_q    <= '0;
         rd0_q       <= 1'b0;
         rd0_last_q  <= 1'b0;
         rd1_q       <= 1'b0;
         rd1_last_q  <= 1'b0;
         fd_q[0]     <= '0;
         fd_q[1]     <= '0;
         fl_q        <= '0;
         wptr_q      <= 1'b0;
         rptr_q      <= 1'b0;
         fcnt_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         rd0_q      <= 1'b0;
         rd1_q      <= rd0_q;
         rd1_last_q <= rd0_last_q;
         fcnt_q     <= fcnt_d;

         if (move) begin
            out_valid_q <= 1'b1;
            if (fifo_ne) begin
               out_data_q <= fd_q[rptr_q];
               out_last_q <= fl_q[rptr_q];
            end else begin
               out_data_q <= bram_rdata_c_ext;
               out_last_q <= rd1_last_q;
            end
         end else if (pop) begin
            out_valid_q <= 1'b0;
         end

         if (push) begin
            fd_q[wptr_q] <= bram_rdata_c_ext;
            fl_q[wptr_q] <= rd1_last_q;
            wptr_q       <= ~wptr_q;
         end
         if (fifo_pop) rptr_q <= ~rptr_q;

         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (num_rows == 8'd0) begin
                     done_q <= 1'b1;
                  end else begin
                     stride_q   <= addr_stride;
                     rows_q     <= num_rows;
                     addr_q     <= base_addr;
                     issued_q   <= 8'd1;
                     rd0_q      <= 1'b1;
                     rd0_last_q <= (num_rows == 8'd1);
                     state_q    <= (num_rows == 8'd1) ? S_DRAIN : S_READ;
                  end
               end
            end
            S_READ: begin
               if (can_issue) begin
                  addr_q     <= addr_q + AWIDTH'(stride_q);
                  issued_q   <= issued_q + 8'd1;
                  rd0_q      <= 1'b1;
                  rd0_last_q <= last_issue;
                  if (last_issue) state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (pop && out_last_q) begin
                  state_q <= S_IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bram_addr_c_ext  = addr_q;
   assign bram_wdata_c_ext = '0;
   assign bram_we_c_ext    = '0;
   assign out_data         = out_data_q;
   assign out_valid        = out_valid_q;
   assign out_last         = out_last_q;
   assign busy             = (state_q != S_IDLE);
   assign done             = done_q;

endmodule

// File: tb/tb_matrix_c_drain.sv
// Scoreboard bench for matrix_c_drain: directed matrices, BRAM model,
// monitor pops expected rows on every handshake.
module tb_matrix_c_drain;

   localparam int AW = 10;
   localparam int SW = 8;
   localparam int RW = 32;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base = '0;
   logic [SW-1:0] stride = '0;
   logic [7:0]    nrows = '0;
   logic [AW-1:0] bram_addr;
   logic [RW-1:0] bram_rdata = '0;
   logic [RW-1:0] bram_wdata;
   logic [3:0]    bram_we;
   logic [RW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          out_last;
   logic          busy, done;

   int vecs = 0;
   int errs = 0;
   int done_cnt = 0;
   int addr_chg = 0;
   logic [RW:0] exp_q[$];

   matrix_c_drain #(
      .DWIDTH(8), .MAT_MUL_SIZE(4), .AWIDTH(AW), .ADDR_STRIDE_WIDTH(SW)
   ) dut (
      .clk(clk), .resetn(resetn), .start(start),
      .base_addr(base), .addr_stride(stride), .num_rows(nrows),
      .bram_addr_c_ext(bram_addr), .bram_rdata_c_ext(bram_rdata),
      .bram_wdata_c_ext(bram_wdata), .bram_we_c_ext(bram_we),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [RW-1:0] pat(input logic [AW-1:0] a);
      return {a[7:0] ^ 8'hA5, 6'd0, a, 8'h3C ^ a[9:2]};
   endfunction

   always @(posedge clk) bram_rdata <= pat(bram_addr);

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   logic          prev_stall = 1'b0;
   logic [RW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;
   logic [AW-1:0] prev_addr = '0;

   always @(negedge clk) begin
      logic [RW:0] e;
      if (resetn) begin
         if (done) done_cnt++;
         if (bram_addr !== prev_addr) addr_chg++;
         if (prev_stall) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_data", out_data, prev_data);
            chk("stall_last", {31'd0, out_last}, {31'd0, prev_last});
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_row", {31'd0, out_valid}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("row_data", out_data, e[RW-1:0]);
               chk("row_last", {31'd0, out_last}, {31'd0, e[RW]});
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end else begin
         prev_stall = 1'b0;
      end
      prev_addr = bram_addr;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Drives start in cycle 0 and returns positioned in cycle 1.
   task automatic launch(input logic [AW-1:0] b, input int s, input int n);
      start  = 1'b1;
      base   = b;
      stride = SW'(s);
      nrows  = 8'(n);
      for (int r = 0; r < n; r++)
         exp_q.push_back({(r == n - 1), pat(AW'(int'(b) + r * s))});
      cyc();
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int lim);
      int c = 0;
      while (done_cnt == d0 && c < lim) begin
         cyc();
         c++;
      end
      chk("done_seen", done_cnt - d0, 1);
   endtask

   initial begin
      int d0, a0;
      logic [3:0] rp;
      rp = 4'b1001;

      #2;
      chk("rst_valid", {31'd0, out_valid}, 0);
      chk("rst_last", {31'd0, out_last}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_addr", {22'd0, bram_addr}, 0);
      chk("rst_data", out_data, 0);
      chk("wdata_zero", bram_wdata, 0);
      chk("we_zero", {28'd0, bram_we}, 0);
      cyc();
      cyc();
      resetn = 1'b1;
      cyc();

      // Full-rate drain with exact cycle timing.
      launch(10'h010, 1, 4);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         if (c <= 4) chk("t1_addr", {22'd0, bram_addr}, 32'h10 + c - 1);
         chk("t1_valid", {31'd0, out_valid}, {31'd0, (c >= 3 && c <= 6)});
         chk("t1_done", {31'd0, done}, {31'd0, (c == 7)});
         chk("t1_busy", {31'd0, busy}, {31'd0, (c < 7)});
         cyc();
      end

      // Backpressure with ready pattern 1,0,0,1.
      d0 = done_cnt;
      a0 = addr_chg;
      launch(10'h020, 1, 4);
      for (int c = 1; c < 60 && done_cnt == d0; c++) begin
         out_ready = rp[c % 4];
         cyc();
      end
      out_ready = 1'b1;
      chk("t2_done", done_cnt - d0, 1);
      chk("t2_reads", addr_chg - a0, 4);
      chk("t2_left", exp_q.size(), 0);
      cyc();

      // Address wrap.
      d0 = done_cnt;
      launch(10'h3FE, 4, 3);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         chk("t3_addr", {22'd0, bram_addr},
             (c == 1) ? 32'h3FE : (c == 2) ? 32'h002 : 32'h006);
         cyc();
      end
      wait_done(d0, 20);
      chk("t3_left", exp_q.size(), 0);
      cyc();

      // Zero rows.
      d0 = done_cnt;
      a0 = int'(bram_addr);
      launch(10'h155, 1, 0);
      @(negedge clk);
      chk("t4_done", {31'd0, done}, 1);
      chk("t4_busy", {31'd0, busy}, 0);
      chk("t4_addr", {22'd0, bram_addr}, a0);
      cyc();
      @(negedge clk);
      chk("t4_done_once", {31'd0, done}, 0);
      for (int c = 0; c < 4; c++) cyc();
      chk("t4_addr_end", {22'd0, bram_addr}, a0);
      chk("t4_pulses", done_cnt - d0, 1);

      // Reset mid-operation after two rows accepted.
      launch(10'h080, 1, 4);
      for (int c = 1; c < 5; c++) cyc();
      chk("t5_pending", exp_q.size(), 2);
      resetn = 1'b0;
      #1;
      exp_q.delete();
      chk("t5_valid", {31'd0, out_valid}, 0);
      chk("t5_last", {31'd0, out_last}, 0);
      chk("t5_busy", {31'd0, busy}, 0);
      chk("t5_addr", {22'd0, bram_addr}, 0);
      chk("t5_data", out_data, 0);
      cyc();
      cyc();
      resetn = 1'b1;
      for (int c = 0; c < 6; c++) cyc();
      d0 = done_cnt;
      launch(10'h100, 3, 2);
      wait_done(d0, 20);
      chk("t5_left", exp_q.size(), 0);
      cyc();

      // Start while busy is ignored.
      d0 = done_cnt;
      launch(10'h040, 2, 4);
      cyc();
      start = 1'b1;
      base  = 10'h200;
      nrows = 8'd1;
      cyc();
      start = 1'b0;
      for (int c = 0; c < 14; c++) cyc();
      chk("t6_pulses", done_cnt - d0, 1);
      chk("t6_left", exp_q.size(), 0);
      chk("t6_busy", {31'd0, busy}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/matrix_c_drain.md
MATRIX_C_DRAIN -- requirements
Module: matrix_c_drain

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, element width in bits.
REQ-002 SHALL have parameter MAT_MUL_SIZE, default 4, elements per BRAM row.
REQ-003 SHALL have parameter AWIDTH, default 10, BRAM address width.
REQ-004 SHALL have parameter ADDR_STRIDE_WIDTH, default 8, row stride width.
REQ-005 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  begin draining one result matrix.
REQ-008 SHALL have port base_addr  input  AWIDTH  address of row 0 in matrix C BRAM.
REQ-009 SHALL have port addr_stride  input  ADDR_STRIDE_WIDTH  address increment per row.
REQ-010 SHALL have port num_rows  input  8  rows to drain; 0 is legal.
REQ-011 SHALL have port bram_addr_c_ext  output  AWIDTH  read address to BRAM C external port.
REQ-012 SHALL have port bram_rdata_c_ext  input  MAT_MUL_SIZE*DWIDTH  BRAM read data, valid 1 cycle after address.
REQ-013 SHALL have port bram_wdata_c_ext  output  MAT_MUL_SIZE*DWIDTH  constant 0.
REQ-014 SHALL have port bram_we_c_ext  output  MAT_MUL_SIZE  constant 0 (read-only).
REQ-015 SHALL have port out_data  output  MAT_MUL_SIZE*DWIDTH  one row of C, unchanged from BRAM.
REQ-016 SHALL have port out_valid / out_ready  output / input  1 each  stream handshake; transfer when both high.
REQ-017 SHALL have port out_last  output  1  high with final row of the matrix.
REQ-018 SHALL have ports busy (output, 1, high outside IDLE) and done (output, 1, one-cycle completion pulse).

Function
REQ-019 SHALL implement FSM IDLE -> READ -> DRAIN -> IDLE; start SHALL be sampled only in IDLE.
REQ-020 SHALL, in IDLE with start=1 and num_rows>0, latch base_addr, addr_stride, num_rows and enter READ.
REQ-021 SHALL, in IDLE with start=1 and num_rows=0, stay IDLE and pulse done the next cycle; no reads, no output.
REQ-022 SHALL drive bram_addr_c_ext = base + r*stride for row r, computed by accumulation, modulo 2^AWIDTH (wrap, no error).
REQ-023 SHALL buffer read data in a 2-entry FIFO; one read in flight maximum per cycle of latency.
REQ-024 SHALL issue a read in a cycle only if (FIFO occupancy + in-flight - pop this cycle) < 2; no row ever dropped or duplicated.
REQ-025 SHALL, with out_ready held high, issue one read per cycle and deliver one row per cycle.
REQ-026 SHALL have latency: start high cycle 0 -> first address cycle 1 -> out_valid first high cycle 3.
REQ-027 SHALL hold out_data/out_last stable while out_valid=1 and out_ready=0.
REQ-028 SHALL enter DRAIN after issuing read num_rows-1, and leave DRAIN for IDLE when FIFO empty and nothing in flight.
REQ-029 SHALL pulse done for exactly one cycle, the cycle after the last-row transfer; busy falls the same cycle.
REQ-030 SHALL ignore start while busy; a start coinciding with the done pulse (FSM already IDLE) SHALL be accepted.
REQ-031 SHALL hold bram_addr_c_ext at its last value when not issuing.

Reset
REQ-032 SHALL, on resetn low, immediately: FSM IDLE, FIFO empty, in-flight cleared, out_valid=0, out_last=0, busy=0, done=0, bram_addr_c_ext=0, out_data=0.
REQ-033 SHALL, on reset mid-operation, discard all pending rows; after release no output until a new start.

Verification
REQ-034 SHALL check: base=0x010, stride=1, num_rows=4, out_ready=1 -> addresses 0x010..0x013 cycles 1-4, rows out cycles 3-6, out_last cycle 6, done cycle 7.
REQ-035 SHALL check: same as REQ-034 with out_ready toggled 1,0,0,1,... -> four rows in order, data stable while stalled, no extra reads beyond FIFO space.
REQ-036 SHALL check: base=0x3FE, stride=4, num_rows=3 -> addresses 0x3FE, 0x002, 0x006.
REQ-037 SHALL check: num_rows=0 with start -> done one cycle later, out_valid never high, bram_addr_c_ext unchanged.
REQ-038 SHALL check: resetn low after second row accepted of num_rows=4 -> outputs reset at once, no further out_valid; new start with num_rows=2 completes normally.
REQ-039 SHALL check: start asserted during READ -> ignored, exactly num_rows rows and one done pulse.
